// File: rtl/l1_pixel_readout_arbiter.sv
// l1_pixel_readout_arbiter
// Reads out one triggered event from NREQ pixel-column hit buffers into a
// single 29-bit TDC word stream, one word per cycle. Each word is tagged with
// the BCID latched at L1A. Words beyond MAXHITS per event are popped and
// discarded. One L1A arriving while busy is held as pending; further L1As
// while the pending slot is full are counted as dropped.
//
// Build option: define READOUT_RR_EN for round-robin column selection
// (persistent pointer). Without it, the lowest-index non-empty column wins.

module l1_pixel_readout_arbiter #(
    parameter int NREQ    = 16,
    parameter int MAXHITS = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 l1a,
    input  logic [11:0]          l1aBCID,
    input  logic [NREQ-1:0]      colHit,
    input  logic [NREQ*17-1:0]   colData,
    output logic [NREQ-1:0]      colRead,
    output logic [28:0]          TDCData,
    output logic                 unreadHit,
    output logic                 busy,
    output logic                 eventDone,
    output logic [19:0]          hitCount,
    output logic [19:0]          flushCount,
    output logic [15:0]          l1aDropCount
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAXHITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [11:0]     cur_bcid;
    logic [HW-1:0]   hits_this_event;
    logic            pend_vld;
    logic [11:0]     pend_bcid;
    logic [IW-1:0]   sel;
    logic            any_hit;
    logic            grant;
    logic            start_event;
    logic [16:0]     sel_word;

    assign any_hit     = |colHit;
    assign grant       = ((state == READ) || (state == FLUSH)) && any_hit;
    assign start_event = (state == IDLE) && (l1a || pend_vld);
    assign sel_word    = colData[sel*17 +: 17];
    assign busy        = (state != IDLE);
    assign eventDone   = (state == DONE);

`ifdef READOUT_RR_EN
    logic [IW-1:0] rr_ptr;

    // Round-robin search: first non-empty column at or after rr_ptr, wrapping.
    always_comb begin
        logic [IW:0] idx;
        logic        found;
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sel   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
            if (!found && colHit[idx[IW-1:0]]) begin
                sel   = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer moves one past every granted column (READ and FLUSH alike).
    // NOTE: the asynchronous reset clears only real state registers; the
    // reset branch must mirror the sensitivity list exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end
    end
`else
    // Fixed priority: lowest-index non-empty column wins.
    always_comb begin
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (colHit[k]) sel = IW'(k);
        end
    end
`endif

    // One-hot pop for the selected column while reading or flushing.
    always_comb begin
        colRead      = '0;
        colRead[sel] = grant;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples pre-edge values regardless of order.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (l1a || pend_vld) state_nxt = READ;
            READ: begin
                if (!any_hit)
                    state_nxt = DONE;
                else if (hits_this_event == HW'(MAXHITS - 1))
                    state_nxt = FLUSH;
            end
            FLUSH: if (!any_hit) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Event context, pending L1A slot and drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_bcid     <= '0;
            pend_vld     <= 1'b0;
            pend_bcid    <= '0;
            l1aDropCount <= '0;
        end else begin
            if (start_event)
                cur_bcid <= pend_vld ? pend_bcid : l1aBCID;
            if (state == IDLE) begin
                // A pending entry is served first; a coincident new l1a
                // takes its place in the slot.
                if (pend_vld) begin
                    pend_vld <= l1a;
                    if (l1a) pend_bcid <= l1aBCID;
                end
            end else if (l1a) begin
                if (!pend_vld) begin
                    pend_vld  <= 1'b1;
                    pend_bcid <= l1aBCID;
                end else if (l1aDropCount != 16'hFFFF) begin
                    l1aDropCount <= l1aDropCount + 16'd1;
                end
            end
        end
    end

    // Output word capture, per-event hit count and global counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TDCData         <= '0;
            unreadHit       <= 1'b0;
            hits_this_event <= '0;
            hitCount        <= '0;
            flushCount      <= '0;
        end else begin
            unreadHit <= (state == READ) && any_hit;
            if (start_event)
                hits_this_event <= '0;
            if ((state == READ) && any_hit) begin
                TDCData         <= {sel_word[16:9], cur_bcid, sel_word[8:0]};
                hits_this_event <= hits_this_event + 1'b1;
                hitCount        <= hitCount + 20'd1;
            end
            if ((state == FLUSH) && any_hit)
                flushCount <= flushCount + 20'd1;
        end
    end

endmodule
